bus_sync_arbiter: RTL and testbench

- Source-side scheduler that lets NUM_REQ requesters share one word-wide clock-domain-crossing bus synchronizer.
- Round-robin arbitration between the requesters.
- Drives the synchronizer's din/din_vld input on a single registered port.
- Enforces a minimum spacing of GAP cycles between issues, so the pulse synchronizer never merges pulses and the source-side data latch is never overwritten before the destination captures it.

---
 rtl/bus_sync_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bus_sync_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sync_arbiter.sv
// Round-robin source-side scheduler feeding one word-wide CDC bus synchronizer,
// spacing issues by GAP cycles. Define BUS_SYNC_ARB_STATS_EN to add issue/stall counters.
module bus_sync_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned GAP        = 6
) (
  input  logic                          src_clk,
  input  logic                          src_rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         sync_din,
  output logic                          sync_din_vld,
  output logic [ID_WIDTH-1:0]           sync_id,
  output logic                          busy
`ifdef BUS_SYNC_ARB_STATS_EN
  ,
  output logic [15:0]                   issue_cnt,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int unsigned CntW = $clog2(GAP);

  typedef enum logic [1:0] {StIdle, StIssue, StHoldoff} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic                    vld_q;
  logic                    busy_q;

  logic                    win_found;
  logic [ID_WIDTH-1:0]     win_idx;
  logic [NUM_REQ-1:0]      win_oh;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    issue_go;
  int unsigned             arb_idx;

  // Scan requesters starting at the pointer; the first pending one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_data  = '0;
    arb_idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!win_found && req[arb_idx]) begin
        win_found        = 1'b1;
        win_idx          = ID_WIDTH'(arb_idx);
        win_oh[arb_idx]  = 1'b1;
        win_data         = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    issue_go = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d  = StIssue;
          issue_go = 1'b1;
        end
      end
      StIssue: begin
        state_d = StHoldoff;
        cnt_d   = CntW'(GAP - 2);
      end
      StHoldoff: begin
        // Last spacing cycle doubles as the arbitration slot for back-to-back issues.
        if (cnt_q == '0) begin
          if (win_found) begin
            state_d  = StIssue;
            issue_go = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    gnt_d = '0;
    if (issue_go) begin
      gnt_d = win_oh;
      ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge src_clk or negedge src_rstn) begin
    if (!src_rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      din_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= issue_go;
      busy_q  <= (state_d != StIdle);
      if (issue_go) begin
        din_q <= win_data;
        id_q  <= win_idx;
      end
    end
  end

  assign gnt          = gnt_q;
  assign sync_din     = din_q;
  assign sync_din_vld = vld_q;
  assign sync_id      = id_q;
  assign busy         = busy_q;

`ifdef BUS_SYNC_ARB_STATS_EN
  logic [15:0] issue_cnt_q, stall_cnt_q;
  logic        stall;

  // A pending request is stalled unless this is the arbitration slot of the window.
  assign stall = (|req) &&
                 ((state_q == StIssue) || ((state_q == StHoldoff) && (cnt_q != '0)));

  always_ff @(posedge src_clk or negedge src_rstn) begin
    if (!src_rstn) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue_go) begin
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bus_sync_arbiter.sv
// Scoreboard bench for bus_sync_arbiter: GAP=6 instance checked by a monitor against
// queued expected issues, plus a GAP=2 instance for the minimum-spacing corner.
module tb_bus_sync_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   req, req2;
  logic [127:0] req_data, req_data2;
  logic [3:0]   gnt, gnt2;
  logic [31:0]  din, din2;
  logic         vld, vld2;
  logic [1:0]   id, id2;
  logic         busy, busy2;
`ifdef BUS_SYNC_ARB_STATS_EN
  logic [15:0]  issue_cnt, stall_cnt, issue_cnt2, stall_cnt2;
`endif

  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  int last_vld = -1000;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_sync_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ID_WIDTH(2), .GAP(6)) dut (
    .src_clk      (clk),
    .src_rstn     (rstn),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .sync_din     (din),
    .sync_din_vld (vld),
    .sync_id      (id),
    .busy         (busy)
`ifdef BUS_SYNC_ARB_STATS_EN
    ,
    .issue_cnt    (issue_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  bus_sync_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ID_WIDTH(2), .GAP(2)) dut2 (
    .src_clk      (clk),
    .src_rstn     (rstn),
    .req          (req2),
    .req_data     (req_data2),
    .gnt          (gnt2),
    .sync_din     (din2),
    .sync_din_vld (vld2),
    .sync_id      (id2),
    .busy         (busy2)
`ifdef BUS_SYNC_ARB_STATS_EN
    ,
    .issue_cnt    (issue_cnt2),
    .stall_cnt    (stall_cnt2)
`endif
  );

  // Pops one expected issue per observed strobe and checks spacing on the GAP=6 instance.
  task automatic monitor();
    exp_t       e;
    logic [3:0] eg;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        last_vld = -1000;
      end else if (vld) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected: cycle %0d id %0d gnt %b, required no issue",
                   cyc, id, gnt);
        end else begin
          e  = sb_q.pop_front();
          eg = 4'b0001 << e.id;
          if (id !== e.id || din !== e.data || gnt !== eg || cyc !== e.at) begin
            errors++;
            $display("FAIL issue_match: got id %0d din %h gnt %b cycle %0d, required id %0d din %h gnt %b cycle %0d",
                     id, din, gnt, cyc, e.id, e.data, eg, e.at);
          end
        end
        checks++;
        if (cyc - last_vld < 6) begin
          errors++;
          $display("FAIL issue_spacing: got %0d cycles, required >= 6", cyc - last_vld);
        end
        last_vld = cyc;
      end else begin
        checks++;
        if (gnt !== 4'b0000) begin
          errors++;
          $display("FAIL gnt_without_vld: got %b, required 0000 at cycle %0d", gnt, cyc);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    req  = '0;
    req2 = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 5;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b, required 0", gnt); end
    if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b, required 0", vld); end
    if (din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h, required 0", din); end
    if (id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d, required 0", id); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if ({gnt2, vld2, din2, id2, busy2} !== '0) begin
      errors++;
      $display("FAIL reset_gap2: got %h, required 0", {gnt2, vld2, din2, id2, busy2});
    end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    int c;
    @(negedge clk);
    c = cyc;
    req = 4'b0010;
    req_data[32 +: 32] = 32'hDEADBEEF;
    sb_q.push_back('{id: 2'd1, data: 32'hDEADBEEF, at: c + 1});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) req = 4'b0000;
      checks++;
      if (busy !== (k <= 6)) begin
        errors++;
        $display("FAIL single_busy: cycle +%0d got %b, required %b", k, busy, (k <= 6));
      end
    end
    checks++;
    if (din !== 32'hDEADBEEF || id !== 2'd1) begin
      errors++;
      $display("FAIL single_hold: got din %h id %0d, required DEADBEEF id 1", din, id);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL single_missing: got %0d pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_saturated();
    int c;
    do_reset();
    c = cyc;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA0A0_0000 | i;
    for (int n = 0; n < 5; n++) begin
      sb_q.push_back('{id: 2'(n % 4), data: 32'hA0A0_0000 | (n % 4), at: c + 1 + 6 * n});
    end
    repeat (25) @(negedge clk);
    req = 4'b0000;
    repeat (8) @(negedge clk);
    checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL saturated_end: got %0d pending busy %b, required 0 pending busy 0",
               sb_q.size(), busy);
      sb_q.delete();
    end
  endtask

  task automatic test_withdrawn();
    int c;
    do_reset();
    c = cyc;
    req = 4'b0101;
    req_data[0 +: 32]  = 32'h0000_C0DE;
    req_data[64 +: 32] = 32'h2222_2222;
    sb_q.push_back('{id: 2'd0, data: 32'h0000_C0DE, at: c + 1});
    repeat (2) @(negedge clk);
    req = 4'b0001;
    req_data[0 +: 32] = 32'h0001_C0DE;
    sb_q.push_back('{id: 2'd0, data: 32'h0001_C0DE, at: c + 7});
    repeat (5) @(negedge clk);
    req = 4'b0000;
    repeat (8) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL withdrawn_missing: got %0d pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int c;
    int r;
    @(negedge clk);
    c = cyc;
    req = 4'b1000;
    req_data[96 +: 32] = 32'h3333_BEEF;
    sb_q.push_back('{id: 2'd3, data: 32'h3333_BEEF, at: c + 1});
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || id !== 2'd3 || din !== 32'h3333_BEEF) begin
      errors++;
      $display("FAIL mid_before: got busy %b id %0d din %h, required 1 3 3333BEEF", busy, id, din);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({gnt, vld, din, id, busy} !== '0) begin
      errors++;
      $display("FAIL mid_async_clear: got %h, required 0", {gnt, vld, din, id, busy});
    end
    @(negedge clk);
    rstn = 1'b1;
    r = cyc;
    sb_q.push_back('{id: 2'd3, data: 32'h3333_BEEF, at: r + 1});
    @(negedge clk);
    req = 4'b0000;
    repeat (8) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL mid_missing: got %0d pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_gap2();
    logic [31:0] d;
    logic [31:0] exp_d;
    @(negedge clk);
    d = 32'h5000_0000;
    exp_d = d;
    req2 = 4'b0001;
    req_data2[0 +: 32] = d;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (vld2 !== 1'((k % 2) == 1)) begin
        errors++;
        $display("FAIL gap2_vld: cycle +%0d got %b, required %b", k, vld2, (k % 2) == 1);
      end
      checks++;
      if ((k % 2) == 1) begin
        if (gnt2 !== 4'b0001 || din2 !== exp_d || id2 !== 2'd0) begin
          errors++;
          $display("FAIL gap2_issue: got gnt %b din %h id %0d, required 0001 %h 0",
                   gnt2, din2, id2, exp_d);
        end
        d = d + 1;
        req_data2[0 +: 32] = d;
        exp_d = d;
      end else if (gnt2 !== 4'b0000) begin
        errors++;
        $display("FAIL gap2_gnt_idle: got %b, required 0000", gnt2);
      end
    end
    req2 = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

`ifdef BUS_SYNC_ARB_STATS_EN
  task automatic test_stats();
    int c;
    do_reset();
    c = cyc;
    req = 4'b0011;
    req_data[0 +: 32]  = 32'h0A0A_0000;
    req_data[32 +: 32] = 32'h0B0B_0001;
    for (int n = 0; n < 10; n++) begin
      sb_q.push_back('{id: 2'(n % 2), data: (n % 2 == 0) ? 32'h0A0A_0000 : 32'h0B0B_0001,
                       at: c + 1 + 6 * n});
    end
    repeat (60) @(negedge clk);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    checks++;
    if (issue_cnt !== 16'd10) begin
      errors++;
      $display("FAIL stats_issue_cnt: got %0d, required 10", issue_cnt);
    end
    checks++;
    if (stall_cnt !== 16'd50) begin
      errors++;
      $display("FAIL stats_stall_cnt: got %0d, required 50", stall_cnt);
    end
    checks++;
    if (issue_cnt2 !== 16'd0 || stall_cnt2 !== 16'd0) begin
      errors++;
      $display("FAIL stats_idle_dut: got %0d %0d, required 0 0", issue_cnt2, stall_cnt2);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL stats_missing: got %0d pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask
`endif

  initial begin
    rstn      = 1'b0;
    req       = '0;
    req2      = '0;
    req_data  = '0;
    req_data2 = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_saturated();
    test_withdrawn();
    test_reset_mid();
    test_gap2();
`ifdef BUS_SYNC_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
